// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the producer-side request bus and the bridge-side packet bus of
//   the UART TX arbiter.
//
//   req_valid_in     producers -> arbiter  per-requester packet pending
//   req_message_in   producers -> arbiter  flattened messages (i at i*MESSAGE_SIZE)
//   req_header_in    producers -> arbiter  flattened headers, same packing
//   req_ready_out    arbiter -> producers  one-hot capture strobe
//   bdge_message_out arbiter -> bridge     registered message
//   bdge_header_out  arbiter -> bridge     registered header, source ID stamped
//   bdge_valid_out   arbiter -> bridge     packet valid
//   bdge_ready_in    bridge -> arbiter     bridge ready
//
//   slave  : the arbiter's view
//   master : the producers/bridge (or testbench) view
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int MESSAGE_SIZE = 512,
  parameter int HEADER_SIZE  = 32
);
  logic [NUM_REQ-1:0]              req_valid_in;
  logic [NUM_REQ*MESSAGE_SIZE-1:0] req_message_in;
  logic [NUM_REQ*HEADER_SIZE-1:0]  req_header_in;
  logic [NUM_REQ-1:0]              req_ready_out;
  logic [MESSAGE_SIZE-1:0]         bdge_message_out;
  logic [HEADER_SIZE-1:0]          bdge_header_out;
  logic                            bdge_valid_out;
  logic                            bdge_ready_in;

  modport slave (
    input  req_valid_in, req_message_in, req_header_in, bdge_ready_in,
    output req_ready_out, bdge_message_out, bdge_header_out, bdge_valid_out
  );

  modport master (
    output req_valid_in, req_message_in, req_header_in, bdge_ready_in,
    input  req_ready_out, bdge_message_out, bdge_header_out, bdge_valid_out
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART TX bridge among NUM_REQ packet producers. A pending
//   requester is picked round-robin, its message and header are captured
//   (source ID stamped into the header's top ID_W bits) and offered to the
//   bridge with valid/ready. A packet the bridge does not take within
//   TIMEOUT_CYCLES is dropped so a dead link cannot wedge the producers.
//
//   clk_in          system clock
//   rst_in          asynchronous active-low reset
//   bus             request and bridge buses (uart_tx_arbiter_if.slave)
//   grant_idx_out   index of the packet held or last sent
//   drop_out        one-cycle pulse when a packet is discarded on timeout
//   sent_count_out  packets accepted by the bridge (wraps)
//   drop_count_out  packets dropped (wraps)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int MESSAGE_SIZE   = 512,
  parameter int HEADER_SIZE    = 32,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int ID_W           = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  uart_tx_arbiter_if.slave bus,
  output logic [ID_W-1:0]  grant_idx_out,
  output logic             drop_out,
  output logic [15:0]      sent_count_out,
  output logic [15:0]      drop_count_out
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                  state, state_next;
  logic [ID_W-1:0]         rr_ptr, pick, offset, ptr_after_grant;
  logic [ID_W:0]           pick_sum;
  logic [2*NUM_REQ-1:0]    valid_dbl;
  logic [NUM_REQ-1:0]      valid_rot;
  logic                    any_req;
  logic                    capture, complete, timeout;
  logic [CNT_W-1:0]        wait_cnt;
  logic [MESSAGE_SIZE-1:0] msg_sel, msg_q;
  logic [HEADER_SIZE-1:0]  hdr_sel, hdr_q;

  // Rotate the request vector so rr_ptr lands at bit 0; the lowest set bit
  // of the rotated vector is then the round-robin winner's distance.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    valid_dbl = {bus.req_valid_in, bus.req_valid_in} >> rr_ptr;
    valid_rot = valid_dbl[NUM_REQ-1:0];
    any_req   = |valid_rot;
    offset    = '0;
    // Descending scan: the last hit written is the nearest one.
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (valid_rot[k]) offset = ID_W'(k);
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (pick_sum >= (ID_W+1)'(NUM_REQ)) pick_sum = pick_sum - (ID_W+1)'(NUM_REQ);
    pick = pick_sum[ID_W-1:0];
  end

  // Mux the winner's data with constant part-selects, then stamp the ID.
  always_comb begin
    msg_sel = '0;
    hdr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == ID_W'(i)) begin
        msg_sel = bus.req_message_in[i*MESSAGE_SIZE +: MESSAGE_SIZE];
        hdr_sel = bus.req_header_in[i*HEADER_SIZE +: HEADER_SIZE];
      end
    end
    hdr_sel[HEADER_SIZE-1 -: ID_W] = pick;
  end

  assign ptr_after_grant = (grant_idx_out == ID_W'(NUM_REQ-1)) ? '0
                                                               : grant_idx_out + 1'b1;

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_next;
  end

  // FSM next-state and strobes. In ISSUE a ready bridge beats the timeout.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          capture    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.bdge_ready_in) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES-1)) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath, pointer and counters.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      // NOTE: the wide packet registers are reset too; the bridge must see
      // all-zero data after reset, so they cannot be left as plain storage.
      msg_q          <= '0;
      hdr_q          <= '0;
      grant_idx_out  <= '0;
      rr_ptr         <= '0;
      wait_cnt       <= '0;
      sent_count_out <= '0;
      drop_count_out <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (capture) begin
        msg_q         <= msg_sel;
        hdr_q         <= hdr_sel;
        grant_idx_out <= pick;
        wait_cnt      <= '0;
      end else if (state == ISSUE && !complete && !timeout) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (complete)            sent_count_out <= sent_count_out + 16'd1;
      if (timeout)             drop_count_out <= drop_count_out + 16'd1;
      if (complete || timeout) rr_ptr         <= ptr_after_grant;
    end
  end

  assign bus.req_ready_out    = capture ? (NUM_REQ'(1) << pick) : '0;
  assign bus.bdge_valid_out   = (state == ISSUE);
  assign bus.bdge_message_out = msg_q;
  assign bus.bdge_header_out  = hdr_q;
  assign drop_out             = timeout;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART TX bridge among NUM_REQ packet producers (e.g. sensor, audio and control message builders).
- Selects one pending requester round-robin and captures its message and header. Stamps the source ID into the header and presents the packet to the bridge with a valid/ready handshake.
- Drops a held packet if the bridge stalls longer than TIMEOUT_CYCLES, so a disconnected laptop cannot lock up the producers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- MESSAGE_SIZE, 512, message width in bits
- HEADER_SIZE, 32, header width in bits
- TIMEOUT_CYCLES, 1000000, maximum cycles a packet waits for bdge_ready_in before being dropped
- ID_W, 3, width of the source-ID field stamped into header bits [HEADER_SIZE-1 -: ID_W]

Ports:
- clk_in  input  1  system clock; single clock domain
- rst_in  input  1  asynchronous, active-low reset
- req_valid_in  input  NUM_REQ  per-requester packet-pending flag
- req_message_in  input  NUM_REQ*MESSAGE_SIZE  flattened messages; requester i at [i*MESSAGE_SIZE +: MESSAGE_SIZE]
- req_header_in  input  NUM_REQ*HEADER_SIZE  flattened headers, same packing
- req_ready_out  output  NUM_REQ  one-hot capture strobe to the granted requester
- bdge_message_out  output  MESSAGE_SIZE  registered message to the bridge
- bdge_header_out  output  HEADER_SIZE  registered header with source ID stamped
- bdge_valid_out  output  1  packet valid to the bridge (drives bridge ctrl_valid_in)
- bdge_ready_in  input  1  bridge ready (from bridge bdge_ready_out)
- grant_idx_out  output  ID_W  index of the packet currently held or last sent
- drop_out  output  1  one-cycle pulse when a packet is discarded on timeout
- sent_count_out  output  16  packets accepted by the bridge, wraps at 2^16
- drop_count_out  output  16  packets dropped, wraps at 2^16

Behaviour:
- Reset (rst_in low, asynchronous): state=IDLE, rr_ptr=0, every output and register 0, including message/header registers and both counters. Reset mid-packet discards the held packet without a drop pulse.
- State IDLE:
  - pick = first i with req_valid_in[i]=1, searching (rr_ptr, rr_ptr+1, ... mod NUM_REQ).
  - req_ready_out = onehot(pick) combinationally when any request is valid, else 0.
  - On that cycle, register message, header and grant_idx_out=pick. Header bits [HEADER_SIZE-1 -: ID_W] are overwritten with pick; the other bits pass unchanged. Go to ISSUE and clear wait_cnt.
- State ISSUE:
  - bdge_valid_out=1; req_ready_out=0.
  - Message and header outputs are held stable until the packet leaves ISSUE.
  - If bdge_ready_in=1: the transfer completes this cycle. sent_count_out+1, rr_ptr=(grant+1) mod NUM_REQ, go to IDLE.
  - Else if wait_cnt==TIMEOUT_CYCLES-1: drop_out=1 this cycle, drop_count_out+1, rr_ptr=(grant+1) mod NUM_REQ, go to IDLE.
  - Else wait_cnt+1.
  - If bdge_ready_in=1 on the timeout cycle, the transfer wins; no drop.
- Latency:
  - Capture cycle N; bdge_valid_out first high at N+1.
  - Back-to-back throughput is at most one packet per 2 cycles: IDLE always costs a cycle.
- Requester contract:
  - A requester holds req_valid_in and its data until it sees its req_ready_out.
  - A requester may deassert req_valid_in before it is granted; the arbiter ignores it.
  - A requester's data is sampled only on the capture cycle.
- Fairness: after requester i is served or dropped, every other pending requester is served before i again.
- bdge_valid_out is registered (state==ISSUE). It never rises while bdge_ready_in is observed only combinationally, so there is no loop through the bridge.
- Counters wrap 0xFFFF->0x0000 silently.

Test Plan:
- Single requester: reset, req_valid_in=4'b0001, header=0x0000_00AA, bdge_ready_in=1 -> req_ready_out=0001 for one cycle; next cycle bdge_valid_out=1, bdge_header_out=0x0000_00AA, grant_idx_out=0; sent_count_out=1.
- Round-robin: req_valid_in=4'b1111 held, bdge_ready_in=1 -> grant order 0,1,2,3,0. Source-ID field of bdge_header_out equals each grant index in turn.
- Bridge stall: bdge_ready_in=0 for 5 cycles during ISSUE, then 1 -> bdge_valid_out and data stable for all 6 cycles, exactly one transfer, sent_count_out=1.
- Timeout: TIMEOUT_CYCLES=8, bdge_ready_in=0 forever -> drop_out pulses on the 8th ISSUE cycle, drop_count_out=1, then return to IDLE; the next requester is granted.
- Timeout tie: bdge_ready_in rises exactly on the timeout cycle -> sent_count_out increments, drop_out stays 0.
- Async reset mid-ISSUE: assert rst_in low between clock edges -> bdge_valid_out, req_ready_out and counters go to 0 immediately. After release, the arbiter grants requester 0 first.
